// File: rtl/note_seq_if.sv
// -----------------------------------------------------------------------------
// note_seq_if
//   Bundles the control and note-table signals of the melody sequencer.
//   The master modport is the sequencer side. The slave modport is the
//   controller, note-table and tone-stage side.
//
//   Signals:
//     start     slave -> master  begin playback from address 0 (level)
//     stop      slave -> master  abort playback
//     loop      slave -> master  replay from address 0 at an end marker
//                                (present only with NOTE_SEQ_LOOP_EN)
//     rom_addr  master -> slave  note-table address
//     rom_data  slave -> master  {divider[DIV_W-1:0], duration[7:0]}
//     divider   master -> slave  phase-step reload value, 0 = rest
//     gate      master -> slave  tone enable
//     busy      master -> slave  playback in progress
//     done      master -> slave  one-cycle end-of-song pulse
// -----------------------------------------------------------------------------
interface note_seq_if #(
    parameter int ADDR_W = 6,
    parameter int DIV_W  = 12
);
    logic              start;
    logic              stop;
`ifdef NOTE_SEQ_LOOP_EN
    logic              loop;
`endif
    logic [ADDR_W-1:0] rom_addr;
    logic [DIV_W+7:0]  rom_data;
    logic [DIV_W-1:0]  divider;
    logic              gate;
    logic              busy;
    logic              done;

`ifdef NOTE_SEQ_LOOP_EN
    modport master (
        input  start, stop, loop, rom_data,
        output rom_addr, divider, gate, busy, done
    );
    modport slave (
        output start, stop, loop, rom_data,
        input  rom_addr, divider, gate, busy, done
    );
`else
    modport master (
        input  start, stop, rom_data,
        output rom_addr, divider, gate, busy, done
    );
    modport slave (
        output start, stop, rom_data,
        input  rom_addr, divider, gate, busy, done
    );
`endif
endinterface

// File: rtl/note_seq.sv
// -----------------------------------------------------------------------------
// note_seq
//   Melody sequencer. It walks an external note table and drives the
//   phase-step divider and the gate for the downstream tone/PDM path. Each
//   table entry is {divider, duration}:
//     - duration == 0 marks the end of the song.
//     - divider == 0 with duration > 0 is a rest.
//   Durations are counted in tempo ticks of TICK_DIV clk cycles. The gate is
//   dropped for the last GAP_TICKS ticks of each note, so repeated pitches
//   stay audibly separate. Notes no longer than GAP_TICKS have no gap.
//
//   Ports:
//     clk   system clock
//     rst   synchronous active-high reset
//     bus   note_seq_if.master: start/stop(/loop) in, rom_addr/rom_data
//           table access, divider/gate/busy/done out
//
//   Build option:
//     NOTE_SEQ_LOOP_EN  When defined, bus.loop=1 makes an end marker restart
//                       at address 0 without leaving the busy states. done
//                       still pulses for one cycle.
//
//   Parameters:
//     TICK_DIV   clk cycles per tempo tick (>= 2)
//     GAP_TICKS  silent ticks at the tail of each note
//     ADDR_W     note-table address width
//     DIV_W      divider width
//
//   State table:
//     state   | meaning
//     --------+-----------------------------------------------------------
//     S_IDLE  | waiting for start; outputs quiet
//     S_FETCH | one cycle; samples rom_data at rom_addr, loads the note
//     S_PLAY  | counts ticks of the current note, opens the gap, advances
//     S_DONE  | one cycle; done pulse, then back to idle
// -----------------------------------------------------------------------------
module note_seq #(
    parameter int TICK_DIV  = 20000,
    parameter int GAP_TICKS = 8,
    parameter int ADDR_W    = 6,
    parameter int DIV_W     = 12
) (
    input  logic       clk,
    input  logic       rst,
    note_seq_if.master bus
);
    localparam int                TICK_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [7:0]        GAP_V     = 8'(GAP_TICKS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_PLAY  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [DIV_W-1:0]  div_q,   div_d;
    logic              gate_q,  gate_d;
    logic              busy_q,  busy_d;
    logic              done_q,  done_d;
    logic [TICK_W-1:0] tick_q,  tick_d;
    logic [7:0]        rem_q,   rem_d;

    logic [DIV_W-1:0]  fld_div;
    logic [7:0]        fld_dur;
    logic [7:0]        rem_dec;
    logic              tick_hit;

    assign fld_div  = bus.rom_data[DIV_W+7:8];
    assign fld_dur  = bus.rom_data[7:0];
    assign rem_dec  = rem_q - 8'd1;
    assign tick_hit = (tick_q == TICK_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            div_q   <= '0;
            gate_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            tick_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            div_q   <= div_d;
            gate_q  <= gate_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            tick_q  <= tick_d;
            rem_q   <= rem_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        div_d   = div_q;
        gate_d  = gate_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        tick_d  = tick_q;
        rem_d   = rem_q;

        if (bus.stop) begin
            // stop beats everything, including a same-cycle start
            state_d = S_IDLE;
            div_d   = '0;
            gate_d  = 1'b0;
            busy_d  = 1'b0;
            tick_d  = '0;
            rem_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        state_d = S_FETCH;
                        addr_d  = '0;
                        busy_d  = 1'b1;
                    end
                end

                S_FETCH: begin
                    if (fld_dur == 8'd0) begin
                        // end marker: the divider field is ignored
                        done_d = 1'b1;
                        gate_d = 1'b0;
                        div_d  = '0;
`ifdef NOTE_SEQ_LOOP_EN
                        if (bus.loop) begin
                            state_d = S_FETCH;
                            addr_d  = '0;
                            busy_d  = 1'b1;
                        end else begin
                            state_d = S_DONE;
                            busy_d  = 1'b0;
                        end
`else
                        state_d = S_DONE;
                        busy_d  = 1'b0;
`endif
                    end else begin
                        state_d = S_PLAY;
                        div_d   = fld_div;
                        rem_d   = fld_dur;
                        tick_d  = '0;
                        gate_d  = (fld_div != '0);
                        busy_d  = 1'b1;
                    end
                end

                S_PLAY: begin
                    if (tick_hit) begin
                        tick_d = '0;
                        rem_d  = rem_dec;
                        if (rem_dec == 8'd0) begin
                            state_d = S_FETCH;
                            addr_d  = addr_q + ADDR_W'(1);
                            gate_d  = 1'b0;
                        end else if (rem_dec == GAP_V) begin
                            // rem only passes through GAP_V when the note is
                            // longer than the gap, so short notes never gap
                            gate_d = 1'b0;
                        end
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end

                S_DONE: begin
                    state_d = S_IDLE;
                end

                default: begin
                    state_d = S_IDLE;
                    div_d   = '0;
                    gate_d  = 1'b0;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    assign bus.rom_addr = addr_q;
    assign bus.divider  = div_q;
    assign bus.gate     = gate_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_note_seq.sv
module tb_note_seq;
    localparam int ADDR_W    = 6;
    localparam int DIV_W     = 12;
    localparam int TICK_DIV  = 4;
    localparam int GAP_TICKS = 1;

    typedef struct packed {
        logic             gate;
        logic [DIV_W-1:0] div;
        logic             busy;
        logic             done;
        logic [ADDR_W-1:0] addr;
    } out_t;

    typedef struct {
        int   n;
        int   load;
        bit   start;
        bit   stop;
        out_t want;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    note_seq_if #(.ADDR_W(ADDR_W), .DIV_W(DIV_W)) bus ();

    note_seq #(
        .TICK_DIV (TICK_DIV),
        .GAP_TICKS(GAP_TICKS),
        .ADDR_W   (ADDR_W),
        .DIV_W    (DIV_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [DIV_W+7:0] rom [64];
    assign bus.rom_data = rom[bus.rom_addr];

    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t vecs[$];
    out_t exp_q[$];

    function automatic logic [DIV_W+7:0] ent(int d, int dur);
        return {DIV_W'(d), 8'(dur)};
    endfunction

    task automatic load_rom(input int k);
        for (int i = 0; i < 64; i++) rom[i] = '0;
        case (k)
            0: begin rom[0] = ent(298, 3); end
            1: begin rom[0] = ent(150, 1); rom[1] = ent(0, 2); end
            2: begin rom[0] = ent(100, 5); rom[1] = ent(200, 5); end
            3: begin for (int i = 0; i < 64; i++) rom[i] = ent(i + 1, 1); end
            4: begin rom[0] = ent(298, 2); end
            default: ;
        endcase
    endtask

    function automatic vec_t mk(int n, bit st, bit sp, bit g, int d, bit b, bit dn, int a);
        vec_t v;
        v.n         = n;
        v.load      = -1;
        v.start     = st;
        v.stop      = sp;
        v.want.gate = g;
        v.want.div  = DIV_W'(d);
        v.want.busy = b;
        v.want.done = dn;
        v.want.addr = ADDR_W'(a);
        return v;
    endfunction

    function automatic vec_t ld(int k);
        vec_t v;
        v      = mk(0, 0, 0, 0, 0, 0, 0, 0);
        v.load = k;
        return v;
    endfunction

    function automatic out_t cur();
        out_t o;
        o.gate = bus.gate;
        o.div  = bus.divider;
        o.busy = bus.busy;
        o.done = bus.done;
        o.addr = bus.rom_addr;
        return o;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, got, want);
        end
    endtask

    initial begin
        int   k;
        out_t got;
        out_t e;

        bus.start = 1'b0;
        bus.stop  = 1'b0;
`ifdef NOTE_SEQ_LOOP_EN
        bus.loop  = 1'b0;
`endif
        load_rom(0);

        // start, stop, gate, div, busy, done, addr per run of cycles
        // song A: (298,3),(0,0)
        vecs.push_back(ld(0));
        vecs.push_back(mk(1, 1, 0, 0,   0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0,   0, 1, 0, 0));
        vecs.push_back(mk(8, 0, 0, 1, 298, 1, 0, 0));
        vecs.push_back(mk(4, 0, 0, 0, 298, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 298, 1, 0, 1));
        vecs.push_back(mk(1, 0, 0, 0,   0, 0, 1, 1));
        vecs.push_back(mk(2, 0, 0, 0,   0, 0, 0, 1));
        // song B: (150,1),(0,2),(0,0)
        vecs.push_back(ld(1));
        vecs.push_back(mk(1, 1, 0, 0,   0, 0, 0, 1));
        vecs.push_back(mk(1, 0, 0, 0,   0, 1, 0, 0));
        vecs.push_back(mk(4, 0, 0, 1, 150, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 150, 1, 0, 1));
        vecs.push_back(mk(8, 0, 0, 0,   0, 1, 0, 1));
        vecs.push_back(mk(1, 0, 0, 0,   0, 1, 0, 2));
        vecs.push_back(mk(1, 0, 0, 0,   0, 0, 1, 2));
        vecs.push_back(mk(2, 0, 0, 0,   0, 0, 0, 2));
        // song C: stop in the second note, restart one cycle later, stop again
        vecs.push_back(ld(2));
        vecs.push_back(mk(1,  1, 0, 0,   0, 0, 0, 2));
        vecs.push_back(mk(1,  0, 0, 0,   0, 1, 0, 0));
        vecs.push_back(mk(16, 0, 0, 1, 100, 1, 0, 0));
        vecs.push_back(mk(4,  0, 0, 0, 100, 1, 0, 0));
        vecs.push_back(mk(1,  0, 0, 0, 100, 1, 0, 1));
        vecs.push_back(mk(2,  0, 0, 1, 200, 1, 0, 1));
        vecs.push_back(mk(1,  0, 1, 1, 200, 1, 0, 1));
        vecs.push_back(mk(1,  0, 0, 0,   0, 0, 0, 1));
        vecs.push_back(mk(1,  1, 0, 0,   0, 0, 0, 1));
        vecs.push_back(mk(1,  0, 0, 0,   0, 1, 0, 0));
        vecs.push_back(mk(1,  0, 0, 1, 100, 1, 0, 0));
        vecs.push_back(mk(1,  0, 1, 1, 100, 1, 0, 0));
        vecs.push_back(mk(2,  0, 0, 0,   0, 0, 0, 0));
        // start+stop together in IDLE, then start held through a whole pass
        vecs.push_back(ld(0));
        vecs.push_back(mk(1, 1, 1, 0,   0, 0, 0, 0));
        vecs.push_back(mk(2, 0, 0, 0,   0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0,   0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0,   0, 1, 0, 0));
        vecs.push_back(mk(8, 1, 0, 1, 298, 1, 0, 0));
        vecs.push_back(mk(4, 1, 0, 0, 298, 1, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 298, 1, 0, 1));
        vecs.push_back(mk(1, 1, 0, 0,   0, 0, 1, 1));
        vecs.push_back(mk(1, 1, 0, 0,   0, 0, 0, 1));
        vecs.push_back(mk(1, 0, 0, 0,   0, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 298, 1, 0, 0));
        vecs.push_back(mk(1, 0, 1, 1, 298, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0,   0, 0, 0, 0));

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk); #1;
        chk("reset_gate", 32'(bus.gate), 0);
        chk("reset_div",  32'(bus.divider), 0);
        chk("reset_busy", 32'(bus.busy), 0);
        chk("reset_done", 32'(bus.done), 0);
        chk("reset_addr", 32'(bus.rom_addr), 0);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].n == 0) begin
                load_rom(vecs[i].load);
            end else begin
                for (int c = 0; c < vecs[i].n; c++) begin
                    @(negedge clk);
                    bus.start = vecs[i].start;
                    bus.stop  = vecs[i].stop;
                    exp_q.push_back(vecs[i].want);
                    #1;
                    got = cur();
                    e   = exp_q.pop_front();
                    n_cmp++;
                    if (got !== e) begin
                        n_bad++;
                        $display("FAIL vec%0d.%0d: got gate=%0b div=%0d busy=%0b done=%0b addr=%0d expected gate=%0b div=%0d busy=%0b done=%0b addr=%0d",
                                 i, c, got.gate, got.div, got.busy, got.done, got.addr,
                                 e.gate, e.div, e.busy, e.done, e.addr);
                    end
                end
            end
        end
        bus.start = 1'b0;
        bus.stop  = 1'b0;

        // reset in the middle of a note
        load_rom(0);
        @(negedge clk); bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        chk("midplay_gate_before", 32'(bus.gate), 1);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0; #1;
        chk("midrst_gate", 32'(bus.gate), 0);
        chk("midrst_div",  32'(bus.divider), 0);
        chk("midrst_busy", 32'(bus.busy), 0);
        chk("midrst_addr", 32'(bus.rom_addr), 0);
        @(negedge clk); #1;
        chk("midrst_idle_busy", 32'(bus.busy), 0);

        // address wrap with no end marker
        load_rom(3);
        @(negedge clk); bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0; #1;
        k = 0;
        while (!(bus.rom_addr == 6'd63 && bus.gate) && k < 500) begin
            @(negedge clk); #1; k++;
        end
        chk("wrap_reach63_div", 32'(bus.divider), 64);
        k = 0;
        while (bus.rom_addr == 6'd63 && k < 20) begin
            @(negedge clk); #1; k++;
        end
        chk("wrap_addr",  32'(bus.rom_addr), 0);
        chk("wrap_busy",  32'(bus.busy), 1);
        chk("wrap_nodone", 32'(bus.done), 0);
        k = 0;
        while (!bus.gate && k < 20) begin
            @(negedge clk); #1; k++;
        end
        chk("wrap_div0", 32'(bus.divider), 1);
        @(negedge clk); bus.stop = 1'b1;
        @(negedge clk); bus.stop = 1'b0; #1;
        chk("wrap_stop_busy", 32'(bus.busy), 0);

`ifdef NOTE_SEQ_LOOP_EN
        load_rom(4);
        bus.loop = 1'b1;
        @(negedge clk); bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0; #1;
        k = 0;
        while (!bus.done && k < 50) begin
            @(negedge clk); #1; k++;
        end
        chk("loop_first_done", 32'(bus.done), 1);
        chk("loop_done_gate",  32'(bus.gate), 0);
        for (int p = 0; p < 2; p++) begin
            int per;
            int busy_low;
            int saw;
            per = 0; busy_low = 0; saw = 0;
            do begin
                @(negedge clk); #1; per++;
                if (!bus.busy) busy_low++;
                if (bus.divider == 12'd298) saw = 1;
            end while (!bus.done && per < 50);
            chk("loop_period",   32'(per), 10);
            chk("loop_busy_low", 32'(busy_low), 0);
            chk("loop_div_back", 32'(saw), 1);
        end
        bus.loop = 1'b0;
        k = 0;
        do begin
            @(negedge clk); #1; k++;
        end while (!bus.done && k < 50);
        chk("noloop_done",      32'(bus.done), 1);
        chk("noloop_done_busy", 32'(bus.busy), 0);
        @(negedge clk); #1;
        chk("noloop_idle_busy", 32'(bus.busy), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
